// File: rtl/program_loader.sv
// Boot-time program loader: framed byte stream in, 16-bit words out to the
// instruction memory write port; holds the CPU in reset until a frame checks.
//
// Ports:
//   CLOCK_50, reset (async active-low)
//   rx_valid/rx_data/rx_ready : byte stream handshake (rx_ready = !mem_we)
//   mem_we/mem_addr/mem_data  : instruction memory write port
//   cpu_hold                  : 1 = processor held in reset
//   done/err                  : last frame loaded OK / rejected
//   word_count                : words written in the current or last frame
module program_loader #(
  parameter int          ADDR_W        = 12,
  parameter int          DATA_W        = 16,
  parameter logic [7:0]  SYNC          = 8'hA5,
  parameter logic        HOLD_AT_RESET = 1'b1
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] word_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_H, S_LEN_L, S_DATA_H,
    S_DATA_L, S_CHECK, S_DONE, S_ERR
  } state_t;

  state_t            r_state;
  logic [3:0]        r_len_h;
  logic [ADDR_W-1:0] r_len;
  logic [7:0]        r_hi;
  logic [7:0]        r_chk;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_hold;
  logic              r_done;
  logic              r_err;
  logic [ADDR_W-1:0] r_cnt;

  logic              w_acc;
  logic [ADDR_W-1:0] w_n;
  logic [ADDR_W-1:0] w_cnt_nx;

  // Stall the source for the one cycle a write is on the port.
  assign rx_ready = !r_we;
  assign w_acc    = rx_valid && rx_ready;
  assign w_n      = ADDR_W'({r_len_h, rx_data});
  assign w_cnt_nx = r_cnt + ADDR_W'(1);

  assign mem_we     = r_we;
  assign mem_addr   = r_addr;
  assign mem_data   = r_data;
  assign cpu_hold   = r_hold;
  assign done       = r_done;
  assign err        = r_err;
  assign word_count = r_cnt;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_len_h <= '0;
      r_len   <= '0;
      r_hi    <= '0;
      r_chk   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_hold  <= HOLD_AT_RESET;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_acc) begin
        unique case (r_state)
          S_IDLE, S_DONE, S_ERR: begin
            // Non-SYNC bytes are dropped and outputs hold.
            if (rx_data == SYNC) begin
              r_state <= S_LEN_H;
              r_hold  <= 1'b1;
              r_done  <= 1'b0;
              r_err   <= 1'b0;
              r_cnt   <= '0;
              r_chk   <= '0;
            end
          end
          S_LEN_H: begin
            if (rx_data[7:4] != 4'd0) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end else begin
              r_len_h <= rx_data[3:0];
              r_state <= S_LEN_L;
            end
          end
          S_LEN_L: begin
            if (w_n == '0) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end else begin
              r_len   <= w_n;
              r_state <= S_DATA_H;
            end
          end
          S_DATA_H: begin
            r_hi    <= rx_data;
            r_chk   <= r_chk ^ rx_data;
            r_state <= S_DATA_L;
          end
          S_DATA_L: begin
            r_chk   <= r_chk ^ rx_data;
            r_we    <= 1'b1;
            r_addr  <= r_cnt;
            r_data  <= DATA_W'({r_hi, rx_data});
            r_cnt   <= w_cnt_nx;
            r_state <= (w_cnt_nx == r_len) ? S_CHECK : S_DATA_H;
          end
          S_CHECK: begin
            if (rx_data == r_chk) begin
              r_state <= S_DONE;
              r_hold  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time program loader for the 16-bit processor: accepts a framed byte stream over a valid/ready handshake, assembles 16-bit instruction words and writes them sequentially into the instruction memory write port starting at address 0. It is the writing end of the instruction-memory interface that the processor's 12-bit PC reads. While a load is in progress, it holds the processor in reset through `cpu_hold`. It releases the processor only after a frame with a valid checksum.

## Interface
- `ADDR_W`, 12: instruction memory address width; word count field width.
- `DATA_W`, 16: instruction word width; fixed at 2 bytes.
- `SYNC`, 8'hA5: frame header byte.
- `HOLD_AT_RESET`, 1: reset value of `cpu_hold`.

Ports:
- `CLOCK_50`  in  1  single clock; everything on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx_valid`  in  1  byte-source valid.
- `rx_data`  in  8  byte value.
- `rx_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  instruction memory write enable, one-cycle pulse per word.
- `mem_addr`  out  ADDR_W  write address.
- `mem_data`  out  DATA_W  write data.
- `cpu_hold`  out  1  1 = processor held in reset.
- `done`  out  1  level; last frame loaded and checksum matched.
- `err`  out  1  level; last frame rejected.
- `word_count`  out  ADDR_W  words written in the current or last frame.

## Operation
- A byte is accepted on a posedge where `rx_valid && rx_ready`. `rx_ready = !mem_we`.
- Frame format: `SYNC`, LEN_H, LEN_L, 2×N data bytes, CHK.
  - Data bytes are sent high byte first.
  - N = {LEN_H[3:0], LEN_L}.
  - CHK = XOR of all 2N data bytes.
- State machine states: IDLE, LEN_H, LEN_L, DATA_H, DATA_L, CHECK, DONE, ERR.
- IDLE:
  - `SYNC` → LEN_H; `cpu_hold` ← 1; `done` ← 0; `err` ← 0; `word_count` ← 0; checksum ← 0.
  - Any other byte is accepted and discarded.
- LEN_H: if byte[7:4] ≠ 0 → ERR; else store byte[3:0] → LEN_L.
- LEN_L: if N = 0 → ERR; else → DATA_H.
- DATA_H: latch high byte, fold it into the checksum → DATA_L.
- DATA_L: on accept, fold the low byte into the checksum, then register:
  - `mem_we` ← 1;
  - `mem_addr` ← `word_count`;
  - `mem_data` ← {hi, lo};
  - `word_count` ← `word_count` + 1.
  - Next state: CHECK if the incremented count = N, else DATA_H.
- Inside DATA_H/DATA_L, a byte equal to `SYNC` is ordinary data.
- CHECK: if byte = checksum → DONE with `cpu_hold` ← 0, `done` ← 1; else → ERR with `err` ← 1, `cpu_hold` stays 1.
- Words already written before an error are not undone.
- DONE/ERR: a `SYNC` byte starts a new frame exactly as IDLE does. Other bytes are discarded, and outputs hold.
- Max N = 4095, so `mem_addr` never wraps within a frame.

## Timing
- Reset (async assert, sync release), in effect immediately on assertion:
  - state IDLE;
  - `cpu_hold` = HOLD_AT_RESET;
  - `mem_we`, `done`, `err` = 0;
  - `mem_addr`, `mem_data`, `word_count`, checksum = 0;
  - `rx_ready` = 1.
- All outputs are registered; `rx_ready` is combinational from `mem_we` only.
- Write latency: the low byte is accepted at edge k. `mem_we`, `mem_addr`, `mem_data` are valid during cycle k..k+1. `mem_we` clears at edge k+1.
- `rx_ready` is 0 during that single cycle. A byte held valid by the source is accepted at edge k+1, never lost or duplicated.
- Peak rate: one word per 3 cycles.
- `cpu_hold` rises the cycle after `SYNC` is accepted. It falls the cycle after a matching CHK is accepted, together with `done` rising.
- `err` rises the cycle after the offending byte: LEN_H, LEN_L or CHK.
- Gaps in `rx_valid` stall the FSM indefinitely; there is no timeout.
- Reset mid-frame aborts the frame and returns everything to reset values, including an in-flight `mem_we`.

## Test plan
- Reset: assert `reset`=0 mid-clock → `cpu_hold`=1, `mem_we`=0, `done`=0, `err`=0, `word_count`=0, `rx_ready`=1 immediately.
- Good frame:
  - Stimulus: A5 00 02 12 34 AB CD 40, `rx_valid` held high.
  - Response: writes (0, 0x1234) then (1, 0xABCD), each `mem_we` exactly 1 cycle with `rx_ready`=0 in that cycle; then `done`=1, `cpu_hold`=0, `word_count`=2.
- Bad checksum:
  - Stimulus: same frame with CHK 0x41.
  - Response: both writes still occur; `err`=1, `done`=0, `cpu_hold`=1.
- Bad length:
  - Stimulus: A5 10 → `err`=1 after LEN_H, no writes.
  - Stimulus: A5 00 00 → `err`=1 after LEN_L, no writes.
- Garbage, stalls and data equal to `SYNC`:
  - Stimulus: 00 FF 3C, then A5 00 01 A5 A5 00 with random `rx_valid` gaps.
  - Response: one write (0, 0xA5A5); `done`=1.
- Reset mid-data:
  - Stimulus: `reset` asserted after A5 00 03 11 22 33.
  - Response: reset values; a subsequent good 1-word frame loads to address 0.
